// File: rtl/agc_pkg.sv
// Shared definitions for the IAGC chain: default data widths, detector state
// encoding and the smallest divisor the downstream divider may ever receive.
package agc_pkg;

    localparam int SAMPLE_SIZE         = 14;
    localparam int AMPLITUDE_DATA_SIZE = SAMPLE_SIZE - 1;
    localparam int MIN_DIVISOR         = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        REPORT  = 2'd2,
        HOLDOFF = 2'd3
    } agc_state_e;

endpackage

// File: rtl/agc_abs_saturate.sv
// Combinational two's-complement to magnitude conversion. The most-negative
// input has no positive counterpart, so it saturates to the largest magnitude.
module agc_abs_saturate
    import agc_pkg::*;
#(
    parameter int WIDTH = SAMPLE_SIZE
) (
    input  logic [WIDTH-1:0] sample,
    output logic [WIDTH-2:0] magnitude
);

    always_comb begin
        magnitude = sample[WIDTH-2:0];
        if (sample[WIDTH-1]) begin
            if (sample[WIDTH-2:0] == '0) begin
                magnitude = '1;
            end else begin
                magnitude = (~sample[WIDTH-2:0]) + (WIDTH-1)'(1);
            end
        end
    end

endmodule

// File: rtl/agc_amplitude_detector.sv
// Windowed peak-amplitude detector feeding the AGC divider with a divisor
// (peak, never 0) and dividend (|setpoint - peak|). Define AGC_DETECTOR_HOLDOFF_EN
// to discard HOLDOFF_LEN valid samples after each reported correction.
module agc_amplitude_detector #(
    parameter int SAMPLE_SIZE         = agc_pkg::SAMPLE_SIZE,
    parameter int AMPLITUDE_DATA_SIZE = agc_pkg::AMPLITUDE_DATA_SIZE,
    parameter int WINDOW_LEN          = 256,
    parameter int DEADBAND            = 16,
    parameter int HOLDOFF_LEN         = 64
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_enable,
    input  logic [SAMPLE_SIZE-1:0]         i_sample,
    input  logic                           i_sample_valid,
    input  logic [AMPLITUDE_DATA_SIZE-1:0] i_setpoint,
    output logic [AMPLITUDE_DATA_SIZE-1:0] o_reference,
    output logic [AMPLITUDE_DATA_SIZE-1:0] o_error,
    output logic                           o_error_sign,
    output logic                           o_valid,
    output logic                           o_in_band
);

    import agc_pkg::*;

    localparam int COUNT_WIDTH = $clog2(WINDOW_LEN + 1);
    localparam logic [COUNT_WIDTH-1:0]         LAST_COUNT  = COUNT_WIDTH'(WINDOW_LEN - 1);
    localparam logic [AMPLITUDE_DATA_SIZE-1:0] DEADBAND_V  = AMPLITUDE_DATA_SIZE'(DEADBAND);
    localparam logic [AMPLITUDE_DATA_SIZE-1:0] MIN_REF     = AMPLITUDE_DATA_SIZE'(MIN_DIVISOR);

    if (WINDOW_LEN < 2 || HOLDOFF_LEN < 1 || AMPLITUDE_DATA_SIZE != SAMPLE_SIZE - 1) begin : g_bad_params
        $error("agc_amplitude_detector: illegal parameter combination");
    end

    agc_state_e state;
    agc_state_e next_state;

    logic [COUNT_WIDTH-1:0]         count;
    logic [AMPLITUDE_DATA_SIZE-1:0] peak;
    logic [AMPLITUDE_DATA_SIZE-1:0] sample_mag;
    logic [AMPLITUDE_DATA_SIZE-1:0] deviation;
    logic                           peak_above;
    logic                           in_band;
    logic                           window_done;
    logic                           holdoff_done;

    agc_abs_saturate #(
        .WIDTH     (SAMPLE_SIZE)
    ) u_abs (
        .sample    (i_sample),
        .magnitude (sample_mag)
    );

    always_comb begin
        peak_above  = peak > i_setpoint;
        deviation   = peak_above ? (peak - i_setpoint) : (i_setpoint - peak);
        in_band     = deviation < DEADBAND_V;
        window_done = i_sample_valid && (count == LAST_COUNT);
    end

`ifdef AGC_DETECTOR_HOLDOFF_EN
    localparam int HOLD_WIDTH = $clog2(HOLDOFF_LEN + 1);
    localparam logic [HOLD_WIDTH-1:0] LAST_HOLD = HOLD_WIDTH'(HOLDOFF_LEN - 1);

    logic [HOLD_WIDTH-1:0] hold_count;

    // Counts discarded samples while the freshly applied gain settles.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hold_count <= '0;
        end else if (i_enable && state == HOLDOFF) begin
            if (i_sample_valid) begin
                hold_count <= hold_count + HOLD_WIDTH'(1);
            end
        end else begin
            hold_count <= '0;
        end
    end

    assign holdoff_done = i_sample_valid && (hold_count == LAST_HOLD);
`else
    assign holdoff_done = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!i_enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = ACQUIRE;
                ACQUIRE: if (window_done) next_state = REPORT;
`ifdef AGC_DETECTOR_HOLDOFF_EN
                REPORT:  next_state = in_band ? ACQUIRE : HOLDOFF;
`else
                REPORT:  next_state = ACQUIRE;
`endif
                HOLDOFF: if (holdoff_done) next_state = ACQUIRE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs only change on an out-of-band report; everything else keeps them.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            peak         <= '0;
            count        <= '0;
            o_reference  <= MIN_REF;
            o_error      <= '0;
            o_error_sign <= 1'b0;
            o_valid      <= 1'b0;
            o_in_band    <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_in_band <= 1'b0;
            if (!i_enable) begin
                peak  <= '0;
                count <= '0;
            end else begin
                case (state)
                    ACQUIRE: begin
                        if (i_sample_valid) begin
                            if (sample_mag > peak) begin
                                peak <= sample_mag;
                            end
                            count <= count + COUNT_WIDTH'(1);
                        end
                    end
                    REPORT: begin
                        peak  <= '0;
                        count <= '0;
                        if (in_band) begin
                            o_in_band <= 1'b1;
                        end else begin
                            o_reference  <= (peak == '0) ? MIN_REF : peak;
                            o_error      <= deviation;
                            o_error_sign <= peak_above;
                            o_valid      <= 1'b1;
                        end
                    end
                    default: begin
                        peak  <= '0;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_agc_amplitude_detector.sv
// Scoreboard bench for agc_amplitude_detector with a 4-sample window; define
// AGC_DETECTOR_HOLDOFF_EN to exercise the 3-sample holdoff build.
module tb_agc_amplitude_detector;

    localparam int SS = 14;
    localparam int AS = 13;

    logic          clock = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [SS-1:0] i_sample;
    logic          i_sample_valid;
    logic [AS-1:0] i_setpoint;
    logic [AS-1:0] o_reference;
    logic [AS-1:0] o_error;
    logic          o_error_sign;
    logic          o_valid;
    logic          o_in_band;

    always #5 clock = ~clock;

    agc_amplitude_detector #(
        .SAMPLE_SIZE         (SS),
        .AMPLITUDE_DATA_SIZE (AS),
        .WINDOW_LEN          (4),
        .DEADBAND            (16),
        .HOLDOFF_LEN         (3)
    ) dut (
        .i_clock        (clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .i_setpoint     (i_setpoint),
        .o_reference    (o_reference),
        .o_error        (o_error),
        .o_error_sign   (o_error_sign),
        .o_valid        (o_valid),
        .o_in_band      (o_in_band)
    );

    typedef struct {
        bit is_valid;
        int ref_v;
        int err_v;
        int sign_v;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Every strobe must match the oldest expectation, including its cycle.
    always @(negedge clock) begin
        if (!i_reset && (o_valid || o_in_band)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe: valid=%0b in_band=%0b at cycle %0d, required no strobe",
                         o_valid, o_in_band, cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("strobe_valid",   32'(o_valid),      32'(mon_e.is_valid));
                checkOutput("strobe_in_band", 32'(o_in_band),    32'(!mon_e.is_valid));
                checkOutput("strobe_cycle",   32'(cyc),          32'(mon_e.due));
                checkOutput("reference",      32'(o_reference),  32'(mon_e.ref_v));
                checkOutput("error",          32'(o_error),      32'(mon_e.err_v));
                checkOutput("error_sign",     32'(o_error_sign), 32'(mon_e.sign_v));
            end
        end
    end

    task automatic applyStimulus(input int s0, input int s1, input int s2, input int s3,
                                 input int setpoint, input bit exp_valid,
                                 input int exp_ref, input int exp_err, input int exp_sign,
                                 input bit report_sample, input int report_value);
        int   s[4];
        exp_t e;
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            i_setpoint     = AS'(setpoint);
            i_sample       = SS'(s[i]);
            i_sample_valid = 1'b1;
        end
        e.is_valid = exp_valid;
        e.ref_v    = exp_ref;
        e.err_v    = exp_err;
        e.sign_v   = exp_sign;
        e.due      = cyc + 2;
        sb.push_back(e);
        @(negedge clock);
        if (report_sample) begin
            i_sample       = SS'(report_value);
            i_sample_valid = 1'b1;
        end else begin
            i_sample_valid = 1'b0;
        end
        @(negedge clock);
        i_sample_valid = 1'b0;
    endtask

    task automatic skipHoldoff();
`ifdef AGC_DETECTOR_HOLDOFF_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            i_sample       = SS'(-8192);
            i_sample_valid = 1'b1;
        end
        @(negedge clock);
        i_sample_valid = 1'b0;
`endif
    endtask

    initial begin
        i_reset        = 1'b1;
        i_enable       = 1'b0;
        i_sample       = '0;
        i_sample_valid = 1'b0;
        i_setpoint     = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset_reference",  32'(o_reference),  32'd1);
        checkOutput("reset_error",      32'(o_error),      32'd0);
        checkOutput("reset_error_sign", 32'(o_error_sign), 32'd0);
        checkOutput("reset_valid",      32'(o_valid),      32'd0);
        checkOutput("reset_in_band",    32'(o_in_band),    32'd0);
        i_reset  = 1'b0;
        i_enable = 1'b1;

        // Nominal, saturation, zero-divisor and sign-high windows.
        applyStimulus(100, -3000, 2500, -200, 4000, 1, 3000, 1000, 0, 0, 0);
        skipHoldoff();
        applyStimulus(10, -8192, 500, 7000, 4000, 1, 8191, 4191, 1, 0, 0);
        skipHoldoff();
        applyStimulus(0, 0, 0, 0, 4000, 1, 1, 4000, 0, 0, 0);
        skipHoldoff();

        // Deadband edges: 10 and 15 are in band, exactly 16 is reported.
        applyStimulus(2990, -100, 5, -2000, 3000, 0, 1, 4000, 0, 0, 0);
        applyStimulus(-2984, 1, 2, 3, 3000, 1, 2984, 16, 0, 0, 0);
        skipHoldoff();
        applyStimulus(3015, 0, 0, 0, 3000, 0, 2984, 16, 0, 0, 0);
        applyStimulus(3000, -3000, 0, 0, 3000, 0, 2984, 16, 0, 0, 0);

        // Abandon a partial window by dropping enable.
        @(negedge clock);
        i_sample = SS'(8000);
        i_sample_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        i_sample_valid = 1'b0;
        i_enable       = 1'b0;
        @(negedge clock);
        checkOutput("idle_hold_reference", 32'(o_reference), 32'd2984);
        checkOutput("idle_hold_error",     32'(o_error),     32'd16);
        i_enable = 1'b1;
        applyStimulus(50, -60, 70, -40, 1000, 1, 70, 930, 0, 0, 0);
        skipHoldoff();

        // A sample in the REPORT cycle must not join the next window.
        applyStimulus(1000, -1200, 900, 0, 2000, 1, 1200, 800, 0, 1, -8000);
        skipHoldoff();
        applyStimulus(300, 200, -100, 50, 2000, 1, 300, 1700, 0, 0, 0);
        skipHoldoff();
        applyStimulus(5000, -6000, 0, 1, 4000, 1, 6000, 2000, 1, 0, 0);
        skipHoldoff();

        // Reset mid-window restores reset outputs and discards the partial window.
        @(negedge clock);
        i_sample = SS'(8000);
        i_sample_valid = 1'b1;
        @(negedge clock);
        @(negedge clock);
        i_sample_valid = 1'b0;
        i_reset        = 1'b1;
        @(negedge clock);
        i_reset = 1'b0;
        checkOutput("midreset_reference", 32'(o_reference), 32'd1);
        checkOutput("midreset_error",     32'(o_error),     32'd0);
        checkOutput("midreset_sign",      32'(o_error_sign), 32'd0);
        applyStimulus(10, 20, -30, 5, 100, 1, 30, 70, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_strobe: no strobe observed, required strobe at cycle %0d", mon_e.due);
        end
        repeat (4) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/agc_amplitude_detector.md
Name: agc_amplitude_detector

Overview:
- Upstream stage of the gain processor in the IAGC chain.
- Measures the peak absolute amplitude of incoming signed samples over a fixed window of valid samples.
- Compares the peak against a programmable setpoint and emits an unsigned divisor/dividend pair plus a one-cycle valid strobe; these feed the divider stage that computes the 8.8 correction ratio.

Parameters:
- SAMPLE_SIZE, 14, width of two's-complement input sample.
- AMPLITUDE_DATA_SIZE, 13, width of unsigned amplitude outputs; must equal SAMPLE_SIZE-1.
- WINDOW_LEN, 256, valid samples per measurement window; minimum 2.
- DEADBAND, 16, deviations strictly below this value are not reported.
- HOLDOFF_LEN, 64, valid samples discarded after each report; used only with the optional feature.

Ports:
- i_clock  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  detector run enable.
- i_sample  in  SAMPLE_SIZE  signed input sample.
- i_sample_valid  in  1  qualifies i_sample for one cycle.
- i_setpoint  in  AMPLITUDE_DATA_SIZE  target peak amplitude; sampled in the REPORT cycle.
- o_reference  out  AMPLITUDE_DATA_SIZE  measured window peak, never 0; this is the divisor.
- o_error  out  AMPLITUDE_DATA_SIZE  |setpoint - peak|; this is the dividend.
- o_error_sign  out  1  1 when peak > setpoint, meaning gain must decrease.
- o_valid  out  1  one-cycle strobe; the other outputs are new and stable.
- o_in_band  out  1  one-cycle strobe when the deviation is inside the deadband.

Behaviour:
- Interface: single clock i_clock; i_reset is synchronous and active-high. The reset port name and polarity are fixed.
- Reset values: o_reference=1, o_error=0, o_error_sign=0, o_valid=0, o_in_band=0; state=IDLE, counter=0, peak=0.
- Reset asserted mid-window discards all partial window state.
- Magnitude:
  - abs(i_sample) saturates to AMPLITUDE_DATA_SIZE bits.
  - Most-negative input (-8192 at default width) maps to 8191.
- States:
  - IDLE: counter and peak held at 0. Go to ACQUIRE when i_enable=1.
  - ACQUIRE: on each i_sample_valid, peak <= max(peak, abs(sample)) and counter increments. On the WINDOW_LEN-th valid sample, go to REPORT.
  - REPORT (exactly 1 cycle): compute from the final peak, then clear peak and counter.
    - If deviation >= DEADBAND: register o_reference=max(peak,1), o_error, o_error_sign, and pulse o_valid.
    - Otherwise: pulse o_in_band and hold the previous output values.
    - Next state is ACQUIRE, or HOLDOFF with the optional feature.
- Valid samples presented during REPORT are discarded and not counted toward the next window.
- Latency: last window sample presented in cycle N -> o_valid (or o_in_band) high in cycle N+2, low again in N+3.
- Divisor rule: peak=0 yields o_reference=1 so the downstream divider never sees a zero divisor. The error is computed from the true peak, so o_error=setpoint.
- o_error_sign=0 when peak == setpoint; that case is always in-band when DEADBAND>0.
- i_enable deasserted in any state: go to IDLE at the next edge and clear peak and counter.
  - Outputs keep their last registered values.
  - A pending REPORT is abandoned with no strobe.
- Non-valid cycles (i_sample_valid=0) change nothing in ACQUIRE.
- Counter width is $clog2(WINDOW_LEN+1). Comparisons are unsigned, and no wrap-around is possible.

Optional Feature:
- Macro: AGC_DETECTOR_HOLDOFF_EN.
- Defined:
  - After a REPORT that asserted o_valid, enter HOLDOFF. Discard HOLDOFF_LEN valid samples (uncounted, not peak-tracked), then go to ACQUIRE.
  - This lets the applied gain settle before the next measurement.
  - An in-band REPORT goes straight to ACQUIRE.
  - i_enable low in HOLDOFF goes to IDLE.
- Undefined: the HOLDOFF state and its counter are absent; REPORT always goes to ACQUIRE.

Decomposition:
- Shared package agc_pkg holds:
  - AMPLITUDE_DATA_SIZE, SAMPLE_SIZE;
  - the state encoding constants (IDLE, ACQUIRE, REPORT, HOLDOFF);
  - the minimum-divisor constant (1).
- One sub-module: agc_abs_saturate, a combinational signed-to-magnitude conversion with saturation, reused by the later gain-apply stage.

Test Plan:
- Reset: assert i_reset 3 cycles -> o_reference=1, o_error=0, o_error_sign=0, o_valid=0, o_in_band=0.
- Nominal window: WINDOW_LEN=4, setpoint=4000, samples 100,-3000,2500,-200 -> o_reference=3000, o_error=1000, o_error_sign=0. o_valid is high exactly 1 cycle, at N+2.
- Saturation: window containing -8192, setpoint 4000 -> o_reference=8191, o_error=4191, o_error_sign=1.
- Zero divisor: window of all 0 samples, setpoint 4000 -> o_reference=1, o_error=4000, o_error_sign=0.
- Deadband: DEADBAND=16, setpoint 3000, peak 2990 -> o_in_band pulses, o_valid stays 0, previous outputs unchanged.
- Abort and drop:
  - Drop i_enable after 2 valid samples, then re-enable -> 4 further samples are needed before the next strobe.
  - A sample issued in the REPORT cycle is not counted.
  - With AGC_DETECTOR_HOLDOFF_EN, HOLDOFF_LEN=3: the 3 samples after an o_valid are ignored.
